// File: rtl/antares_seq_divider_pkg.sv
// Shared types and helpers for the Antares sequential divider.
// Holds FSM encodings, iteration count and operand sign handling.
package antares_seq_divider_pkg;

    localparam int unsigned DIV_WIDTH      = 32;
    localparam int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_CNT_WIDTH  = 5;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] dividend_abs;
        logic [DIV_WIDTH-1:0] divisor_abs;
        logic                 neg_q;
        logic                 neg_r;
    } div_operands_t;

    function automatic logic [DIV_WIDTH-1:0] neg_if(
        input logic                 neg,
        input logic [DIV_WIDTH-1:0] value
    );
        return neg ? (~value + 32'd1) : value;
    endfunction

    // Magnitudes are taken as unsigned, so |-2^31| stays 0x80000000.
    function automatic div_operands_t capture(
        input logic                 is_signed,
        input logic [DIV_WIDTH-1:0] num,
        input logic [DIV_WIDTH-1:0] den
    );
        div_operands_t ops;
        ops.dividend_abs = neg_if(is_signed & num[DIV_WIDTH-1], num);
        ops.divisor_abs  = neg_if(is_signed & den[DIV_WIDTH-1], den);
        ops.neg_q        = is_signed & (num[DIV_WIDTH-1] ^ den[DIV_WIDTH-1]);
        ops.neg_r        = is_signed & num[DIV_WIDTH-1];
        return ops;
    endfunction

endpackage

// File: rtl/antares_seq_divider_step.sv
// One radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor and emit one quotient bit.
module antares_seq_divider_step
    import antares_seq_divider_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic [DIV_WIDTH-1:0] dq,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_next,
    output logic [DIV_WIDTH-1:0] dq_next
);

    logic [DIV_WIDTH:0] trial;

    always_comb begin
        trial    = {rem, dq[DIV_WIDTH-1]} - {1'b0, divisor};
        rem_next = {rem[DIV_WIDTH-2:0], dq[DIV_WIDTH-1]};
        dq_next  = {dq[DIV_WIDTH-2:0], 1'b0};
        if (!trial[DIV_WIDTH]) begin
            rem_next = trial[DIV_WIDTH-1:0];
            dq_next  = {dq[DIV_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/antares_seq_divider.sv
// 32-bit signed/unsigned sequential divider, one quotient bit per cycle.
// Results are valid on the first cycle div_stall drops after a start.
module antares_seq_divider
    import antares_seq_divider_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_divs,
    input  logic                 op_divu,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_stall
);

    div_state_t state;
    div_state_t state_next;

    logic [DIV_WIDTH-1:0]     rem;
    logic [DIV_WIDTH-1:0]     dq;
    logic [DIV_WIDTH-1:0]     dvsr;
    logic                     neg_q;
    logic                     neg_r;
    logic [DIV_CNT_WIDTH-1:0] cnt;

    logic                 start;
    logic                 accept;
    div_operands_t        ops;
    logic [DIV_WIDTH-1:0] rem_step;
    logic [DIV_WIDTH-1:0] dq_step;

    assign start  = op_divs | op_divu;
    assign accept = (state == DIV_IDLE) && start;

    // Signed wins when both start pulses arrive together.
    always_comb begin
        ops = capture(op_divs, dividend, divisor);
    end

    antares_seq_divider_step u_step (
        .rem      (rem),
        .dq       (dq),
        .divisor  (dvsr),
        .rem_next (rem_step),
        .dq_next  (dq_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_stall  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                div_stall = 1'b1;
                if (cnt == '0) begin
                    state_next = DIV_IDLE;
                end
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            dq    <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            rem   <= '0;
            dq    <= ops.dividend_abs;
            dvsr  <= ops.divisor_abs;
            neg_q <= ops.neg_q;
            neg_r <= ops.neg_r;
            cnt   <= DIV_CNT_WIDTH'(DIV_ITERATIONS - 1);
        end else if (state == DIV_BUSY) begin
            rem <= rem_step;
            dq  <= dq_step;
            cnt <= cnt - 1'b1;
        end
    end

    assign quotient  = neg_if(neg_q, dq);
    assign remainder = neg_if(neg_r, rem);

endmodule

// File: tb/tb_antares_seq_divider.sv
// Self-checking bench for antares_seq_divider: directed corner cases,
// randomized operands against an arithmetic model, busy/reset scenarios.
module tb_antares_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_divs;
    logic        op_divu;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_stall;

    int checks = 0;
    int fails  = 0;

    antares_seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .op_divs   (op_divs),
        .op_divu   (op_divu),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_stall (div_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a start for one cycle, then scramble the operand inputs.
    task automatic start_op(input logic s, input logic u,
                            input logic [31:0] a, input logic [31:0] b);
        op_divs  = s;
        op_divu  = u;
        dividend = a;
        divisor  = b;
        tick();
        op_divs  = 1'b0;
        op_divu  = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Counts stalled cycles until div_stall drops, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (div_stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    // MIPS-style division from plain arithmetic on magnitudes.
    function automatic void model(input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        logic [31:0] ua;
        logic [31:0] ub;
        logic        na;
        logic        nb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ua = na ? 32'(0 - a) : a;
        ub = nb ? 32'(0 - b) : b;
        if (ub == 0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (na != nb) q = 32'(0 - q);
        if (na) r = 32'(0 - r);
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        op_divs  = 1'b0;
        op_divu  = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (div_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall got %0b want 0", div_stall);
        end
        checks++;
        if (quotient !== 32'h0 || remainder !== 32'h0) begin
            fails++;
            $display("FAIL reset_results got q=%h r=%h want 0/0",
                     quotient, remainder);
        end
    endtask

    task automatic test_directed();
        logic [65:0]  vec [8];
        logic [31:0]  want_q [8];
        logic [31:0]  want_r [8];
        int n;
        vec[0] = {2'b01, 32'd100, 32'd7};
        want_q[0] = 32'd14;        want_r[0] = 32'd2;
        vec[1] = {2'b10, 32'hFFFF_FFF9, 32'd2};
        want_q[1] = 32'hFFFF_FFFD; want_r[1] = 32'hFFFF_FFFF;
        vec[2] = {2'b10, 32'd7, 32'hFFFF_FFFE};
        want_q[2] = 32'hFFFF_FFFD; want_r[2] = 32'h1;
        vec[3] = {2'b10, 32'h8000_0000, 32'hFFFF_FFFF};
        want_q[3] = 32'h8000_0000; want_r[3] = 32'h0;
        vec[4] = {2'b01, 32'hFFFF_FFFF, 32'd1};
        want_q[4] = 32'hFFFF_FFFF; want_r[4] = 32'h0;
        vec[5] = {2'b01, 32'd5, 32'd0};
        want_q[5] = 32'hFFFF_FFFF; want_r[5] = 32'd5;
        vec[6] = {2'b11, 32'hFFFF_FFF8, 32'd3};
        want_q[6] = 32'hFFFF_FFFE; want_r[6] = 32'hFFFF_FFFE;
        vec[7] = {2'b10, 32'hFFFF_FFFB, 32'd0};
        want_q[7] = 32'h1;         want_r[7] = 32'hFFFF_FFFB;
        for (int i = 0; i < 8; i++) begin
            start_op(vec[i][65], vec[i][64], vec[i][63:32], vec[i][31:0]);
            wait_done(n);
            checks++;
            if (n != 32) begin
                fails++;
                $display("FAIL dir%0d_stall_cycles got %0d want 32", i, n);
            end
            checks++;
            if (quotient !== want_q[i] || remainder !== want_r[i]) begin
                fails++;
                $display("FAIL dir%0d_result got q=%h r=%h want q=%h r=%h",
                         i, quotient, remainder, want_q[i], want_r[i]);
            end
            tick();
            checks++;
            if (quotient !== want_q[i] || div_stall !== 1'b0) begin
                fails++;
                $display("FAIL dir%0d_hold got q=%h stall=%0b want q=%h 0",
                         i, quotient, div_stall, want_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        s;
        logic        u;
        int n;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'(0 - $urandom_range(1, 15));
                default: b = (i % 8 == 0) ? 32'h0 : (a >> $urandom_range(1, 31));
            endcase
            s = 1'($urandom_range(0, 1));
            u = ~s | 1'($urandom_range(0, 1));
            model(s, a, b, eq, er);
            start_op(s, u, a, b);
            wait_done(n);
            checks++;
            if (n != 32) begin
                fails++;
                $display("FAIL rnd%0d_stall_cycles got %0d want 32", i, n);
            end
            checks++;
            if (quotient !== eq || remainder !== er) begin
                fails++;
                $display("FAIL rnd%0d s=%0b %h/%h got q=%h r=%h want q=%h r=%h",
                         i, s, a, b, quotient, remainder, eq, er);
            end
        end
    endtask

    task automatic test_busy_ignore_and_back_to_back();
        int cyc;
        int n;
        start_op(1'b0, 1'b1, 32'd1000, 32'd10);
        repeat (11) tick();
        start_op(1'b0, 1'b1, 32'd50, 32'd5);
        cyc = 13;
        while (div_stall === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        checks++;
        if (cyc != 33) begin
            fails++;
            $display("FAIL busy_done_cycle got %0d want 33", cyc);
        end
        checks++;
        if (quotient !== 32'd100 || remainder !== 32'd0) begin
            fails++;
            $display("FAIL busy_ignore got q=%0d r=%0d want 100/0",
                     quotient, remainder);
        end
        start_op(1'b0, 1'b1, 32'd9, 32'd4);
        checks++;
        if (div_stall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept got stall=%0b want 1", div_stall);
        end
        wait_done(n);
        checks++;
        if (n != 32) begin
            fails++;
            $display("FAIL b2b_stall_cycles got %0d want 32", n);
        end
        checks++;
        if (quotient !== 32'd2 || remainder !== 32'd1) begin
            fails++;
            $display("FAIL b2b_result got q=%0d r=%0d want 2/1",
                     quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (div_stall !== 1'b0) begin
            fails++;
            $display("FAIL abort_stall got %0b want 0", div_stall);
        end
        checks++;
        if (quotient !== 32'h0 || remainder !== 32'h0) begin
            fails++;
            $display("FAIL abort_results got q=%h r=%h want 0/0",
                     quotient, remainder);
        end
        tick();
        start_op(1'b0, 1'b1, 32'd20, 32'd6);
        wait_done(n);
        checks++;
        if (n != 32) begin
            fails++;
            $display("FAIL abort_restart_cycles got %0d want 32", n);
        end
        checks++;
        if (quotient !== 32'd3 || remainder !== 32'd2) begin
            fails++;
            $display("FAIL abort_restart got q=%0d r=%0d want 3/2",
                     quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore_and_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
